zipo_fetch: RTL and testbench

Instruction fetch stage for the zipocpu RV64 core. It owns the program counter and issues word reads to instruction memory. It buffers returned instructions in a small FIFO and presents them one at a time, with their PCs, to the decode/execute stage over a valid/ready handshake. Branch and jump targets from downstream enter through a redirect port, which flushes all buffered and in-flight work.

---
 rtl/zipo_fetch_if.sv | 30 +++
 rtl/zipo_fetch.sv | 117 +++++++++++
 tb/tb_zipo_fetch.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/zipo_fetch_if.sv
// zipo_fetch_if: bundles the fetch stage's memory, redirect and instruction
// handshake signals.
//   master: the fetch stage (drives mem_req/mem_addr and inst_*).
//   slave : the environment (memory, redirect source, decode stage).
//   mem_req/mem_addr     - word read request and its byte address
//   mem_rdata            - 64-bit read data, valid the cycle after mem_req
//   redirect_valid/_pc   - downstream PC change (flushes the stage)
//   inst_valid/_ready    - instruction handshake
//   inst/inst_pc         - instruction at the buffer head and its PC
interface zipo_fetch_if;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [63:0] mem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc,
    input  mem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc,
    output mem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/zipo_fetch.sv
// zipo_fetch: instruction fetch stage for the zipocpu RV64 core.
// Owns the fetch PC, issues one word read per cycle while the instruction
// buffer has room for it, buffers returned words with their PCs in a FIFO and
// presents the head to decode over valid/ready. A redirect flushes buffered
// and in-flight work and restarts fetching at the new PC.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - zipo_fetch_if.master (memory, redirect and instruction handshake)
`ifndef INITIAL_PC
`define INITIAL_PC 64'h0
`endif

module zipo_fetch #(
  parameter logic [63:0] INITIAL_PC = `INITIAL_PC,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  zipo_fetch_if.master bus
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  logic [63:0]   pc_q, pc_d;
  logic          pending_q, pending_d;
  logic [63:0]   pending_pc_q, pending_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   fifo_inst_q [FIFO_DEPTH];
  logic [31:0]   fifo_inst_d [FIFO_DEPTH];
  logic [63:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [63:0]   fifo_pc_d   [FIFO_DEPTH];

  logic          pop;
  logic          push;
  logic          req;
  logic [31:0]   rsp_word;
  logic [CW:0]   occupancy;

  // Occupancy counts the in-flight response and credits a same-cycle pop, so
  // a request is only made when its data is guaranteed a slot.
  always_comb begin
    pop       = (count_q != '0) & bus.inst_ready & ~bus.redirect_valid;
    occupancy = {1'b0, count_q} + (CW + 1)'(pending_q) - (CW + 1)'(pop);
    req       = ~rst & ~bus.redirect_valid & (occupancy < DEPTH_L);
    push      = pending_q & ~bus.redirect_valid;
    rsp_word  = pending_pc_q[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
  end

  always_comb begin
    pc_d         = pc_q;
    pending_d    = 1'b0;
    pending_pc_d = pending_pc_q;
    count_d      = count_q;
    head_d       = head_q;
    tail_d       = tail_q;
    fifo_inst_d  = fifo_inst_q;
    fifo_pc_d    = fifo_pc_q;

    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc & ~64'h3;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (req) begin
        pending_d    = 1'b1;
        pending_pc_d = pc_q;
        pc_d         = pc_q + 64'd4;
      end
      if (push) begin
        fifo_inst_d[tail_q] = rsp_word;
        fifo_pc_d[tail_q]   = pending_pc_q;
        tail_d              = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= INITIAL_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= '0;
      count_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      fifo_inst_q  <= fifo_inst_d;
      fifo_pc_q    <= fifo_pc_d;
    end
  end

  assign bus.mem_req    = req;
  assign bus.mem_addr   = pc_q;
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst       = fifo_inst_q[head_q];
  assign bus.inst_pc    = fifo_pc_q[head_q];

endmodule

// File: tb/tb_zipo_fetch.sv
// tb_zipo_fetch: directed self-checking bench for zipo_fetch (INITIAL_PC=0,
// FIFO_DEPTH=4). A one-cycle-latency memory model answers every request with
// the aligned doubleword containing it, or with a fixed pattern when
// fixed_rdata is set.
module tb_zipo_fetch;

  logic clk;
  logic rst;
  logic fixed_rdata;
  int   checks;
  int   errors;
  int   req_pulses;

  zipo_fetch_if bus ();

  zipo_fetch #(
    .INITIAL_PC (64'h0),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  always @(posedge clk) begin
    if (fixed_rdata)
      bus.mem_rdata <= 64'hAAAA_BBBB_1111_2222;
    else
      bus.mem_rdata <= {word_of({bus.mem_addr[63:3], 3'b100}),
                        word_of({bus.mem_addr[63:3], 3'b000})};
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    checks             = 0;
    errors             = 0;
    req_pulses         = 0;
    fixed_rdata        = 1'b0;
    rst                = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.inst_ready     = 1'b0;
    bus.mem_rdata      = '0;

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      check("rst_req",   64'(bus.mem_req),    64'h0);
      check("rst_valid", 64'(bus.inst_valid), 64'h0);
      check("rst_addr",  bus.mem_addr,        64'h0);
      check("rst_inst",  64'(bus.inst),       64'h0);
      check("rst_ipc",   bus.inst_pc,         64'h0);
    end

    // Streaming: first request in cycle C, valid from C+2
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    #1;
    check("c_req",  64'(bus.mem_req), 64'h1);
    check("c_addr", bus.mem_addr,     64'h0);
    tick(); #1;
    check("c1_valid", 64'(bus.inst_valid), 64'h0);
    check("c1_addr",  bus.mem_addr,        64'h4);
    for (int k = 0; k < 4; k++) begin
      tick(); #1;
      check("str_valid", 64'(bus.inst_valid), 64'h1);
      check("str_pc",    bus.inst_pc,         64'(4 * k));
      check("str_inst",  64'(bus.inst),       64'(word_of(64'(4 * k))));
      check("str_req",   64'(bus.mem_req),    64'h1);
    end

    // Word select: redirect to 0 with a fixed doubleword
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h0;
    fixed_rdata        = 1'b1;
    #1;
    check("ws_redir_req", 64'(bus.mem_req), 64'h0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("ws_addr0", bus.mem_addr,     64'h0);
    check("ws_req0",  64'(bus.mem_req), 64'h1);
    tick();
    tick(); #1;
    check("ws_valid0", 64'(bus.inst_valid), 64'h1);
    check("ws_pc0",    bus.inst_pc,         64'h0);
    check("ws_lo",     64'(bus.inst),       64'h1111_2222);
    tick(); #1;
    check("ws_pc4",    bus.inst_pc,         64'h4);
    check("ws_hi",     64'(bus.inst),       64'hAAAA_BBBB);

    // Back-pressure: redirect to 0x40, ready low
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h40;
    bus.inst_ready     = 1'b0;
    fixed_rdata        = 1'b0;
    #1;
    check("bp_redir_req", 64'(bus.mem_req), 64'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      bus.redirect_valid = 1'b0;
      #1;
      if (bus.mem_req) req_pulses++;
    end
    check("bp_pulses", 64'(req_pulses),      64'd4);
    check("bp_req_lo", 64'(bus.mem_req),     64'h0);
    check("bp_valid",  64'(bus.inst_valid),  64'h1);
    check("bp_pc",     bus.inst_pc,          64'h40);
    check("bp_inst",   64'(bus.inst),        64'(word_of(64'h40)));
    // One-cycle ready: pop and new request in the same cycle
    bus.inst_ready = 1'b1;
    #1;
    check("bp_pop_req",  64'(bus.mem_req), 64'h1);
    check("bp_pop_addr", bus.mem_addr,     64'h50);
    tick();
    bus.inst_ready = 1'b0;
    #1;
    check("bp_next_pc",   bus.inst_pc,      64'h44);
    check("bp_next_inst", 64'(bus.inst),    64'(word_of(64'h44)));
    check("bp_req_again", 64'(bus.mem_req), 64'h0);

    // Redirect while the 0x50 response is arriving, ready high (no pop)
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 64'h103;
    bus.inst_ready     = 1'b1;
    #1;
    check("rd_req", 64'(bus.mem_req), 64'h0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("rd_valid1", 64'(bus.inst_valid), 64'h0);
    check("rd_addr1",  bus.mem_addr,        64'h100);
    check("rd_req1",   64'(bus.mem_req),    64'h1);
    tick(); #1;
    check("rd_valid2", 64'(bus.inst_valid), 64'h0);
    check("rd_addr2",  bus.mem_addr,        64'h104);
    tick();
    bus.inst_ready = 1'b0;
    #1;
    check("rd_valid3", 64'(bus.inst_valid), 64'h1);
    check("rd_pc3",    bus.inst_pc,         64'h100);
    check("rd_inst3",  64'(bus.inst),       64'(word_of(64'h100)));
    tick();
    tick(); #1;
    // Three entries buffered and one response pending
    check("rm_pc_hold", bus.inst_pc,      64'h100);
    check("rm_req",     64'(bus.mem_req), 64'h0);
    check("rm_addr",    bus.mem_addr,     64'h110);

    // Reset mid-stream
    rst = 1'b1;
    #1;
    check("rm_rst_req", 64'(bus.mem_req), 64'h0);
    tick(); #1;
    check("rm_valid", 64'(bus.inst_valid), 64'h0);
    check("rm_inst",  64'(bus.inst),       64'h0);
    check("rm_ipc",   bus.inst_pc,         64'h0);
    check("rm_addr0", bus.mem_addr,        64'h0);
    rst = 1'b0;
    #1;
    check("rm_restart_req", 64'(bus.mem_req), 64'h1);
    tick();
    tick(); #1;
    check("rm_restart_valid", 64'(bus.inst_valid), 64'h1);
    check("rm_restart_pc",    bus.inst_pc,         64'h0);
    check("rm_restart_inst",  64'(bus.inst),       64'(word_of(64'h0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
